uart_mem_streamer: RTL

- Reader-side counterpart to the UART data-collection path: walks the output memory from address 0 to NUM_DATA-1 and serialises each byte directly onto the TX line as 8N1 UART frames.
- Bit timing comes from an internal baud counter on the system clock, so no divided UART clock is needed.
- Sits between out_MEM (zero-latency combinational read) and the RsTx pin.
- Drop-in alternative to the separate send-controller/transmitter pair.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_baud_tick.sv | 41 ++++
 rtl/uart_mem_streamer.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package    : uart_pkg                                                      |
// | Description: Shared constants for the UART memory streamer: FSM state      |
// |              encodings, data width and the bit-period derivation.          |
// | Options    : UART_TX_PARITY_EN adds the PARITY state encoding.             |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package uart_pkg;

   localparam int DATA_BITS = 8;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_LOAD   = 3'd1;
   localparam logic [2:0] ST_START  = 3'd2;
   localparam logic [2:0] ST_DATA   = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;
   localparam logic [2:0] ST_DONE   = 3'd5;
`ifdef UART_TX_PARITY_EN
   localparam logic [2:0] ST_PARITY = 3'd6;
`endif

   // Clock cycles per UART bit; the ratio is expected to be an exact integer >= 2.
   function automatic int calc_bit_cycles(input int clk_rate, input int baud_rate);
      return clk_rate / baud_rate;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : uart_baud_tick                                                |
// | Description: Bit-period counter on the system clock. Counts 0..BIT_CYCLES-1|
// |              and wraps; tick marks the last cycle of each bit period.      |
// | Ports      : clk   - system clock                                          |
// |              rst   - asynchronous active-low reset                         |
// |              clear - hold the counter at zero                              |
// |              tick  - high while count == BIT_CYCLES-1                      |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module uart_baud_tick #(
   parameter int BIT_CYCLES = 1000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);

   localparam int                 c_cnt_w   = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
   localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(BIT_CYCLES - 1);
   localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

   logic [c_cnt_w-1:0] r_cnt;

   // Wrapping on tick makes every state exit at a bit boundary restart the count.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (clear || tick) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + c_cnt_one;
      end
   end

   assign tick = (r_cnt == c_cnt_max);

endmodule
`default_nettype wire

// File: rtl/uart_mem_streamer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : uart_mem_streamer                                             |
// | Description: Walks memory addresses 0..NUM_DATA-1 and sends each byte on   |
// |              tx_out as an 8N1 UART frame (8E1 with parity enabled).        |
// | Ports      : clk         - system clock                                    |
// |              rst         - asynchronous active-low reset                   |
// |              send_start  - level run request, sampled in IDLE only         |
// |              mem_rd_data - combinational read data for mem_rd_sel          |
// |              mem_rd_sel  - memory read address (current byte pointer)      |
// |              tx_out      - serial line, idle high                          |
// |              busy        - high from first LOAD until DONE                 |
// |              finish      - high while in DONE                              |
// | Options    : UART_TX_PARITY_EN - even parity bit between data and stop.    |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module uart_mem_streamer
   import uart_pkg::*;
#(
   parameter int NUM_DATA  = 10000,
   parameter int CLK_RATE  = 9600000,
   parameter int BAUD_RATE = 9600,
   parameter int ADDR_W    = 14
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              send_start,
   input  logic [7:0]        mem_rd_data,
   output logic [ADDR_W-1:0] mem_rd_sel,
   output logic              tx_out,
   output logic              busy,
   output logic              finish
);

   localparam int                BIT_CYCLES = calc_bit_cycles(CLK_RATE, BAUD_RATE);
   localparam logic [ADDR_W-1:0] c_last_ptr = ADDR_W'(NUM_DATA - 1);
   localparam logic [ADDR_W-1:0] c_ptr_one  = ADDR_W'(1);
   localparam logic [2:0]        c_last_bit = 3'(DATA_BITS - 1);

   logic [2:0]        r_state,   w_state_nxt;
   logic [ADDR_W-1:0] r_ptr,     w_ptr_nxt;
   logic [7:0]        r_shift,   w_shift_nxt;
   logic [2:0]        r_bit_idx, w_bit_idx_nxt;
   logic              r_tx,      w_tx_nxt;
   logic              r_busy,    w_busy_nxt;
   logic              r_finish,  w_finish_nxt;
   logic              w_tick;
   logic              w_clear;

   // Untimed states keep the baud counter at zero so START begins a full bit.
   assign w_clear = (r_state == ST_IDLE) || (r_state == ST_LOAD) || (r_state == ST_DONE);

   uart_baud_tick #(
      .BIT_CYCLES (BIT_CYCLES)
   ) u_baud_tick (
      .clk   (clk),
      .rst   (rst),
      .clear (w_clear),
      .tick  (w_tick)
   );

   always_comb begin
      w_state_nxt   = r_state;
      w_ptr_nxt     = r_ptr;
      w_shift_nxt   = r_shift;
      w_bit_idx_nxt = r_bit_idx;
      case (r_state)
         ST_IDLE: begin
            if (send_start) begin
               w_state_nxt = ST_LOAD;
               w_ptr_nxt   = '0;
            end
         end
         ST_LOAD: begin
            w_shift_nxt = mem_rd_data;
            w_state_nxt = ST_START;
         end
         ST_START: begin
            if (w_tick) begin
               w_state_nxt   = ST_DATA;
               w_bit_idx_nxt = '0;
            end
         end
         ST_DATA: begin
            if (w_tick) begin
               // Rotate rather than shift: after 8 bits the byte is intact again,
               // which lets the parity bit be computed from the register.
               w_shift_nxt = {r_shift[0], r_shift[7:1]};
               if (r_bit_idx == c_last_bit) begin
`ifdef UART_TX_PARITY_EN
                  w_state_nxt = ST_PARITY;
`else
                  w_state_nxt = ST_STOP;
`endif
               end else begin
                  w_bit_idx_nxt = r_bit_idx + 3'd1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            if (w_tick) begin
               w_state_nxt = ST_STOP;
            end
         end
`endif
         ST_STOP: begin
            if (w_tick) begin
               if (r_ptr == c_last_ptr) begin
                  w_state_nxt = ST_DONE;
               end else begin
                  w_ptr_nxt   = r_ptr + c_ptr_one;
                  w_state_nxt = ST_LOAD;
               end
            end
         end
         ST_DONE: begin
            if (!send_start) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Outputs are decoded from the next state and registered so they change
   // on the same edge as the state and never glitch.
   always_comb begin
      w_tx_nxt     = 1'b1;
      w_busy_nxt   = 1'b0;
      w_finish_nxt = 1'b0;
      case (w_state_nxt)
         ST_LOAD: begin
            w_busy_nxt = 1'b1;
         end
         ST_START: begin
            w_tx_nxt   = 1'b0;
            w_busy_nxt = 1'b1;
         end
         ST_DATA: begin
            w_tx_nxt   = w_shift_nxt[0];
            w_busy_nxt = 1'b1;
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            w_tx_nxt   = ^w_shift_nxt;
            w_busy_nxt = 1'b1;
         end
`endif
         ST_STOP: begin
            w_busy_nxt = 1'b1;
         end
         ST_DONE: begin
            w_finish_nxt = 1'b1;
         end
         default: begin
            w_tx_nxt = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= ST_IDLE;
         r_ptr     <= '0;
         r_shift   <= '0;
         r_bit_idx <= '0;
         r_tx      <= 1'b1;
         r_busy    <= 1'b0;
         r_finish  <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_ptr     <= w_ptr_nxt;
         r_shift   <= w_shift_nxt;
         r_bit_idx <= w_bit_idx_nxt;
         r_tx      <= w_tx_nxt;
         r_busy    <= w_busy_nxt;
         r_finish  <= w_finish_nxt;
      end
   end

   assign mem_rd_sel = r_ptr;
   assign tx_out     = r_tx;
   assign busy       = r_busy;
   assign finish     = r_finish;

endmodule
`default_nettype wire
